// File: rtl/frame_load_sequencer.sv
// frame_load_sequencer: owns the BRAM port for one 32x32 frame. It requests a
// download from the UART loader, forwards and counts de-duplicated loader
// writes, aborts to ERR on a stalled load, then launches the peak-search engine
// and waits for its completion pulse. Status flags and a frame counter are
// exported for LEDs and debug.
module frame_load_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int FRAME_WORDS = 1024,
    parameter int TIMEOUT_CYC = 25_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              ldr_wr_start_o,
    input  logic              ldr_wr_en_i,
    input  logic [ADDR_W-1:0] ldr_wr_addr_i,
    input  logic [DATA_W-1:0] ldr_wr_data_i,
    input  logic [ADDR_W-1:0] eng_rd_addr_i,
    output logic              eng_start_o,
    input  logic              eng_done_i,
    output logic              bram_we_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [DATA_W-1:0] bram_din_o,
    output logic              busy_o,
    output logic              frame_ok_o,
    output logic              err_timeout_o,
    output logic [7:0]        frame_cnt_o,
    output logic [ADDR_W:0]   load_count_o
);

    // Stall counter only needs to reach TIMEOUT_CYC-1.
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_RUN,
        S_DONE,
        S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic                start_d1_q;
    logic [ADDR_W-1:0]   last_addr_q;
    logic [ADDR_W:0]     load_count_q;
    logic [TO_W-1:0]     timeout_q;
    logic                bram_we_q;
    logic [ADDR_W-1:0]   bram_waddr_q;
    logic [DATA_W-1:0]   bram_din_q;
    logic                ldr_wr_start_q;
    logic                eng_start_q;
    logic                busy_q;
    logic                frame_ok_q;
    logic                err_timeout_q;
    logic [7:0]          frame_cnt_q;

    logic start_rise;
    logic wr_event;

    assign start_rise = start_i & ~start_d1_q;

    // A held-high enable on an unchanged address is the same byte, not a new
    // write; the first write of a load is always accepted. Abort kills it.
    assign wr_event = (state_q == S_LOAD) & ldr_wr_en_i & ~abort_i &
                      ((load_count_q == '0) | (ldr_wr_addr_i != last_addr_q));

    // Next-state decode; abort beats everything except reset.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start_rise) state_d = S_LOAD;
                S_LOAD: begin
                    if (wr_event) begin
                        if (ldr_wr_addr_i == LAST_ADDR) state_d = S_ARM;
                    end else if (timeout_q == TO_LAST) begin
                        state_d = S_ERR;
                    end
                end
                S_ARM:  state_d = S_RUN;
                S_RUN:  if (eng_done_i) state_d = S_DONE;
                S_DONE: if (start_rise) state_d = S_LOAD;
                S_ERR:  if (start_rise) state_d = S_LOAD;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, datapath capture and registered outputs.
    always_ff @(posedge clk_i) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q        <= S_IDLE;
            start_d1_q     <= 1'b0;
            last_addr_q    <= '0;
            load_count_q   <= '0;
            timeout_q      <= '0;
            bram_we_q      <= 1'b0;
            bram_waddr_q   <= '0;
            bram_din_q     <= '0;
            ldr_wr_start_q <= 1'b0;
            eng_start_q    <= 1'b0;
            busy_q         <= 1'b0;
            frame_ok_q     <= 1'b0;
            err_timeout_q  <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            start_d1_q <= start_i;

            // Write forwarding: one-cycle pulse, one cycle after the event.
            bram_we_q <= wr_event;
            if (wr_event) begin
                bram_waddr_q <= ldr_wr_addr_i;
                bram_din_q   <= ldr_wr_data_i;
                last_addr_q  <= ldr_wr_addr_i;
                load_count_q <= load_count_q + 1'b1;
            end

            // Fresh load: forget the previous frame's progress.
            if (state_d == S_LOAD && state_q != S_LOAD) begin
                load_count_q <= '0;
                last_addr_q  <= '0;
                timeout_q    <= '0;
            end else if (state_q == S_LOAD) begin
                timeout_q <= wr_event ? '0 : timeout_q + 1'b1;
            end

            // Raised only from the second LOAD cycle on, so the loader always
            // sees at least two low cycles between consecutive loads.
            ldr_wr_start_q <= (state_d == S_LOAD) && (state_q == S_LOAD);
            // Engine launch leaves ARM, after the final BRAM write has issued.
            eng_start_q    <= (state_q == S_ARM) && (state_d == S_RUN);
            busy_q         <= (state_d == S_LOAD) || (state_d == S_ARM) ||
                              (state_d == S_RUN);
            frame_ok_q     <= (state_d == S_DONE);
            err_timeout_q  <= (state_d == S_ERR);

            if (state_q == S_RUN && state_d == S_DONE) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    // The loader owns the BRAM address while a load is being written back.
    assign bram_addr_o    = (state_q == S_LOAD || state_q == S_ARM) ? bram_waddr_q
                                                                    : eng_rd_addr_i;
    assign bram_we_o      = bram_we_q;
    assign bram_din_o     = bram_din_q;
    assign ldr_wr_start_o = ldr_wr_start_q;
    assign eng_start_o    = eng_start_q;
    assign busy_o         = busy_q;
    assign frame_ok_o     = frame_ok_q;
    assign err_timeout_o  = err_timeout_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign load_count_o   = load_count_q;

endmodule

// File: tb/tb_frame_load_sequencer.sv
// tb_frame_load_sequencer: randomized stimulus for frame_load_sequencer with a
// transaction-level reference model (expected BRAM write stream, frame count,
// timeout arithmetic).
module tb_frame_load_sequencer;

    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 8;
    localparam int FRAME_WORDS = 1024;
    localparam int TIMEOUT_CYC = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              ldr_wr_start;
    logic              ldr_wr_en;
    logic [ADDR_W-1:0] ldr_wr_addr;
    logic [DATA_W-1:0] ldr_wr_data;
    logic [ADDR_W-1:0] eng_rd_addr;
    logic              eng_start;
    logic              eng_done;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              busy;
    logic              frame_ok;
    logic              err_timeout;
    logic [7:0]        frame_cnt;
    logic [ADDR_W:0]   load_count;

    always #5 clk = ~clk;

    frame_load_sequencer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FRAME_WORDS(FRAME_WORDS),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .abort_i       (abort),
        .ldr_wr_start_o(ldr_wr_start),
        .ldr_wr_en_i   (ldr_wr_en),
        .ldr_wr_addr_i (ldr_wr_addr),
        .ldr_wr_data_i (ldr_wr_data),
        .eng_rd_addr_i (eng_rd_addr),
        .eng_start_o   (eng_start),
        .eng_done_i    (eng_done),
        .bram_we_o     (bram_we),
        .bram_addr_o   (bram_addr),
        .bram_din_o    (bram_din),
        .busy_o        (busy),
        .frame_ok_o    (frame_ok),
        .err_timeout_o (err_timeout),
        .frame_cnt_o   (frame_cnt),
        .load_count_o  (load_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: which loader writes must reach the BRAM, in order.
    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    bit  m_loading = 1'b0;
    int  m_count   = 0;
    int  m_last    = 0;
    int  m_frames  = 0;

    // Observation counters maintained by the monitor.
    int  wr_seen       = 0;
    int  eng_start_cnt = 0;
    int  low_run       = 0;
    bit  had_high      = 1'b0;
    bit  prev_ldr      = 1'b0;
    wr_t mon_w;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one loader cycle; the model decides if it is a new write.
    task automatic send(input int addr, input int data, input bit en);
        ldr_wr_addr = addr[ADDR_W-1:0];
        ldr_wr_data = data[DATA_W-1:0];
        ldr_wr_en   = en;
        if (m_loading && en && (m_count == 0 || addr != m_last)) begin
            exp_q.push_back('{addr, data & 255});
            m_count++;
            m_last = addr;
            if (addr == FRAME_WORDS - 1) m_loading = 1'b0;
        end
        tick();
    endtask

    task automatic start_frame();
        ldr_wr_en = 1'b0;
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        m_loading = 1'b1;
        m_count   = 0;
        for (int i = 0; i < 8 && !ldr_wr_start; i++) tick();
        check("ldr_wr_start_up", ldr_wr_start, 1);
        check("load_count_clear", load_count, 0);
        check("busy_load", busy, 1);
    endtask

    task automatic do_abort();
        ldr_wr_en = 1'b0;
        abort = 1'b1;
        m_loading = 1'b0;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ldr_start", ldr_wr_start, 0);
        check("abort_we", bram_we, 0);
    endtask

    // After the final address: expect one launch, then complete the frame.
    task automatic finish_engine();
        int pre;
        ldr_wr_en = 1'b0;
        pre = eng_start_cnt;
        repeat (4) tick();
        check("eng_start_once", eng_start_cnt - pre, 1);
        check("busy_run", busy, 1);
        check("frame_ok_run", frame_ok, 0);
        eng_rd_addr = ADDR_W'($urandom);
        #1;
        check("bram_addr_passthru", bram_addr, eng_rd_addr);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        m_frames++;
        check("frame_ok", frame_ok, 1);
        check("frame_cnt", frame_cnt, m_frames & 255);
        check("busy_done", busy, 0);
        check("pending_writes", exp_q.size(), 0);
    endtask

    // Monitor: compare each BRAM write against the model and watch handshakes.
    always @(negedge clk) begin
        if (!rst) begin
            if (bram_we) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 1, 0);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("we_addr", bram_addr, mon_w.addr);
                    check("we_data", bram_din, mon_w.data);
                end
            end
            if (eng_start) begin
                eng_start_cnt++;
                check("eng_start_after_last_we", exp_q.size(), 0);
            end
            if (ldr_wr_start) begin
                if (!prev_ldr && had_high) check("ldr_start_gap", 32'(low_run >= 2), 1);
                had_high = 1'b1;
                low_run  = 0;
            end else begin
                low_run++;
            end
            prev_ldr = ldr_wr_start;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int w0;
        int reps;
        int d;
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        ldr_wr_en   = 1'b0;
        ldr_wr_addr = '0;
        ldr_wr_data = '0;
        eng_rd_addr = '0;
        eng_done    = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_busy", busy, 0);
        check("rst_frame_ok", frame_ok, 0);
        check("rst_err", err_timeout, 0);
        check("rst_ldr_start", ldr_wr_start, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_bram_we", bram_we, 0);
        check("rst_bram_addr", bram_addr, 0);
        check("rst_bram_din", bram_din, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_load_count", load_count, 0);
        rst = 1'b0;
        tick();

        // Frame 1: sequential addresses, enable held high, data = addr.
        start_frame();
        w0 = wr_seen;
        for (int a = 0; a < FRAME_WORDS; a++) send(a, a & 255, 1'b1);
        finish_engine();
        check("frame1_writes", wr_seen - w0, FRAME_WORDS);
        check("frame1_load_count", load_count, FRAME_WORDS);

        // Frame 2: random repeats, gaps and data; repeated bytes must collapse.
        start_frame();
        w0 = wr_seen;
        for (int a = 0; a < FRAME_WORDS; a++) begin
            reps = $urandom_range(1, 3);
            for (int g = $urandom_range(0, 3); g > 0; g--) send(a, 0, 1'b0);
            for (int r = 0; r < reps; r++) begin
                d = int'($urandom_range(0, 255));
                send(a, d, 1'b1);
            end
        end
        finish_engine();
        check("frame2_writes", wr_seen - w0, FRAME_WORDS);

        // Stall after addr 10: ERR exactly TIMEOUT_CYC cycles after last write.
        start_frame();
        for (int a = 0; a <= 10; a++) send(a, int'($urandom_range(0, 255)), 1'b1);
        ldr_wr_en = 1'b0;
        repeat (TIMEOUT_CYC - 1) tick();
        check("stall_err_early", err_timeout, 0);
        check("stall_busy_early", busy, 1);
        tick();
        m_loading = 1'b0;
        check("stall_err", err_timeout, 1);
        check("stall_busy", busy, 0);
        check("stall_load_count", load_count, 11);
        check("stall_frame_cnt", frame_cnt, m_frames & 255);

        // Write on the final timeout cycle wins; the counter then restarts.
        start_frame();
        for (int a = 0; a <= 5; a++) send(a, int'($urandom_range(0, 255)), 1'b1);
        ldr_wr_en = 1'b0;
        repeat (TIMEOUT_CYC - 1) tick();
        send(6, int'($urandom_range(0, 255)), 1'b1);
        check("coincide_err", err_timeout, 0);
        check("coincide_busy", busy, 1);
        check("coincide_we", bram_we, 1);
        ldr_wr_en = 1'b0;
        repeat (TIMEOUT_CYC - 1) tick();
        check("coincide_err_restart", err_timeout, 0);
        tick();
        m_loading = 1'b0;
        check("coincide_err_late", err_timeout, 1);

        // Abort after addr 500: nothing more reaches the BRAM.
        start_frame();
        w0 = wr_seen;
        for (int a = 0; a <= 500; a++) send(a, int'($urandom_range(0, 255)), 1'b1);
        do_abort();
        for (int a = 501; a <= 510; a++) send(a, int'($urandom_range(0, 255)), 1'b1);
        check("abort_writes", wr_seen - w0, 501);
        check("abort_frame_cnt", frame_cnt, m_frames & 255);
        check("abort_ldr_idle", ldr_wr_start, 0);

        // Same address held 5 cycles -> one write; start_rise while busy ignored.
        start_frame();
        w0 = wr_seen;
        repeat (5) send(0, int'($urandom_range(0, 255)), 1'b1);
        repeat (5) send(1, int'($urandom_range(0, 255)), 1'b1);
        check("repeat_writes", wr_seen - w0, 2);
        check("repeat_load_count", load_count, 2);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        check("busy_start_ignored", load_count, 2);
        check("busy_still", busy, 1);
        do_abort();

        // eng_done in IDLE is ignored.
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        check("idle_done_frame_cnt", frame_cnt, m_frames & 255);
        check("idle_done_frame_ok", frame_ok, 0);
        check("idle_done_busy", busy, 0);
        check("final_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
